counter_share_ctrl: RTL and testbench

//   Sequencer and arbiter for the shared W-bit up-counter.
//   Two requesters each supply a start value and a terminal value. The block:
//   - grants the counter round-robin;
//   - loads the winner's start value and counts up, wrapping modulo 2^W;
//   - honours a global hold;
//   - pulses done[i] when the terminal value is reached.
//   It is the single owner of the counter register; no other logic may write count.

---
 rtl/counter_share_ctrl.sv | 128 ++++++++++++
 tb/tb_counter_share_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_ctrl.sv
// Round-robin sequencer for one shared W-bit up-counter serving two requesters.
// The winner's start/terminal values are latched at grant; done/abort pulse once on completion.
module counter_share_ctrl #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [2*W-1:0] load_val,
    input  logic [2*W-1:0] limit,
    input  logic           hold,
    output logic [1:0]     grant,
    output logic           busy,
    output logic [W-1:0]   count,
    output logic [1:0]     done,
    output logic [1:0]     abort
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lim_q, lim_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     done_q, done_d;
    logic [1:0]     abort_q, abort_d;
    logic           src_q, src_d;
    logic           last_q, last_d;
    logic           win;
    logic [1:0]     src_onehot;

    logic [W-1:0]   load_arr  [2];
    logic [W-1:0]   limit_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            assign load_arr[gi]  = load_val[gi*W +: W];
            assign limit_arr[gi] = limit[gi*W +: W];
        end
    endgenerate

    assign src_onehot = src_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        grant_d = grant_q;
        src_d   = src_q;
        last_d  = last_q;
        done_d  = 2'b00;
        abort_d = 2'b00;
        // On a tie the requester that was not served last wins.
        win     = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    count_d = load_arr[win];
                    lim_d   = limit_arr[win];
                    src_d   = win;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!req[src_q]) begin
                    abort_d = src_onehot;
                    grant_d = 2'b00;
                    last_d  = src_q;
                    state_d = IDLE;
                end else if (count_q == lim_q) begin
                    done_d  = src_onehot;
                    grant_d = 2'b00;
                    last_d  = src_q;
                    state_d = IDLE;
                end else if (hold) begin
                    state_d = PAUSE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PAUSE: begin
                if (!req[src_q]) begin
                    abort_d = src_onehot;
                    grant_d = 2'b00;
                    last_d  = src_q;
                    state_d = IDLE;
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            abort_q <= 2'b00;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
    assign count = count_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Directed table-driven bench for counter_share_ctrl (W=3) plus hand sequences for reset corners.
module tb_counter_share_ctrl;

    localparam int W = 3;

    logic           clk;
    logic           reset;
    logic [1:0]     req;
    logic [2*W-1:0] load_val;
    logic [2*W-1:0] limit;
    logic           hold;
    logic [1:0]     grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [1:0]     done;
    logic [1:0]     abort;

    int n_checks = 0;
    int n_fail   = 0;

    counter_share_ctrl #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .limit    (limit),
        .hold     (hold),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done),
        .abort    (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [5:0] ld;
        logic [5:0] lim;
        logic       hold;
        logic [1:0] g;
        logic       b;
        logic [2:0] c;
        logic [1:0] d;
        logic [1:0] a;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] pk(input int v1, input int v0);
        logic [2:0] h;
        logic [2:0] l;
        h = v1[2:0];
        l = v0[2:0];
        return {h, l};
    endfunction

    task automatic add(input logic [1:0] r, input logic [5:0] ld, input logic [5:0] lim,
                       input logic h, input logic [1:0] g, input logic b, input int c,
                       input logic [1:0] d, input logic [1:0] a);
        vec_t v;
        v.req = r; v.ld = ld; v.lim = lim; v.hold = h;
        v.g = g; v.b = b; v.c = c[2:0]; v.d = d; v.a = a;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] g, input logic b,
                           input logic [2:0] c, input logic [1:0] d, input logic [1:0] a);
        chk({tag, ".grant"}, idx, {6'd0, grant}, {6'd0, g});
        chk({tag, ".busy"},  idx, {7'd0, busy},  {7'd0, b});
        chk({tag, ".count"}, idx, {5'd0, count}, {5'd0, c});
        chk({tag, ".done"},  idx, {6'd0, done},  {6'd0, d});
        chk({tag, ".abort"}, idx, {6'd0, abort}, {6'd0, a});
        $display("%s %0d: req=%b hold=%b grant=%b busy=%b count=%0d done=%b abort=%b",
                 tag, idx, req, hold, grant, busy, count, done, abort);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Tie from reset: req0 first, then req1, then req0 again.
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b01, 1, 2, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b00, 0, 3, 2'b01, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b10, 1, 6, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b10, 1, 7, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b00, 0, 7, 2'b10, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b01, 1, 2, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b11, pk(6,2), pk(7,3), 0, 2'b00, 0, 3, 2'b01, 2'b00);
        add(2'b00, pk(6,2), pk(7,3), 0, 2'b00, 0, 3, 2'b00, 2'b00);
        // Basic count 2..5 for requester 0.
        add(2'b01, pk(0,2), pk(0,5), 0, 2'b01, 1, 2, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,5), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,5), 0, 2'b01, 1, 4, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,5), 0, 2'b01, 1, 5, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,5), 0, 2'b00, 0, 5, 2'b01, 2'b00);
        add(2'b00, pk(0,2), pk(0,5), 0, 2'b00, 0, 5, 2'b00, 2'b00);
        // Wrap 6,7,0,1 for requester 1; inputs changed after grant must be ignored.
        add(2'b10, pk(6,0), pk(1,0), 0, 2'b10, 1, 6, 2'b00, 2'b00);
        add(2'b10, pk(0,0), pk(7,7), 0, 2'b10, 1, 7, 2'b00, 2'b00);
        add(2'b10, pk(0,0), pk(7,7), 0, 2'b10, 1, 0, 2'b00, 2'b00);
        add(2'b10, pk(0,0), pk(7,7), 0, 2'b10, 1, 1, 2'b00, 2'b00);
        add(2'b10, pk(0,0), pk(7,7), 0, 2'b00, 0, 1, 2'b10, 2'b00);
        add(2'b00, pk(0,0), pk(7,7), 0, 2'b00, 0, 1, 2'b00, 2'b00);
        // Hold for three cycles at count 3.
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 2, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 1, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 1, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 1, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 4, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 5, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b01, 1, 6, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,6), 0, 2'b00, 0, 6, 2'b01, 2'b00);
        add(2'b00, pk(0,2), pk(0,6), 0, 2'b00, 0, 6, 2'b00, 2'b00);
        // Owner drops req at count 4.
        add(2'b01, pk(0,2), pk(0,7), 0, 2'b01, 1, 2, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,7), 0, 2'b01, 1, 3, 2'b00, 2'b00);
        add(2'b01, pk(0,2), pk(0,7), 0, 2'b01, 1, 4, 2'b00, 2'b00);
        add(2'b00, pk(0,2), pk(0,7), 0, 2'b00, 0, 4, 2'b00, 2'b01);
        add(2'b00, pk(0,2), pk(0,7), 0, 2'b00, 0, 4, 2'b00, 2'b00);
        // Terminal equals start: done one edge after grant.
        add(2'b10, pk(3,0), pk(3,0), 0, 2'b10, 1, 3, 2'b00, 2'b00);
        add(2'b10, pk(3,0), pk(3,0), 0, 2'b00, 0, 3, 2'b10, 2'b00);
        add(2'b00, pk(3,0), pk(3,0), 0, 2'b00, 0, 3, 2'b00, 2'b00);
        // Drop req while paused.
        add(2'b01, pk(0,0), pk(0,7), 0, 2'b01, 1, 0, 2'b00, 2'b00);
        add(2'b01, pk(0,0), pk(0,7), 1, 2'b01, 1, 0, 2'b00, 2'b00);
        add(2'b00, pk(0,0), pk(0,7), 1, 2'b00, 0, 0, 2'b00, 2'b01);
        add(2'b00, pk(0,0), pk(0,7), 0, 2'b00, 0, 0, 2'b00, 2'b00);

        reset    = 1'b0;
        req      = 2'b11;
        load_val = pk(6,2);
        limit    = pk(7,3);
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 2'b00, 1'b0, 3'd0, 2'b00, 2'b00);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            load_val = vecs[i].ld;
            limit    = vecs[i].lim;
            hold     = vecs[i].hold;
            @(posedge clk);
            #1;
            chk_all("vec", i, vecs[i].g, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].a);
            @(negedge clk);
        end

        // Asynchronous reset mid-run at count 5, then tie on release.
        req      = 2'b01;
        load_val = pk(0,3);
        limit    = pk(0,7);
        hold     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("arst_run", i, 2'b01, 1'b1, 3'(3 + i), 2'b00, 2'b00);
        end
        #2;
        reset = 1'b0;
        #1;
        chk_all("arst_now", 0, 2'b00, 1'b0, 3'd0, 2'b00, 2'b00);
        req = 2'b11;
        @(posedge clk);
        #1;
        chk_all("arst_held", 0, 2'b00, 1'b0, 3'd0, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst_rel", 0, 2'b01, 1'b1, 3'd3, 2'b00, 2'b00);
        @(negedge clk);
        req = 2'b00;
        @(posedge clk);
        #1;
        chk_all("arst_drop", 0, 2'b00, 1'b0, 3'd3, 2'b00, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
